// File: rtl/adder_host_pkg.sv
// ============================================================================
// adder_host_pkg
// Shared types and default constants for the adder host sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_host_pkg;

    // Default operand width and WAIT-state timeout
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 15;

    // Host sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } hostst_t;

endpackage

`default_nettype wire

// File: rtl/host_timeout_counter.sv
// ============================================================================
// host_timeout_counter
// Cycle counter with synchronous clear, count enable and a terminal flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module host_timeout_counter
    import adder_host_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic term
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count enabled cycles; clear restarts from zero and the count parks at terminal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + CW'(1);
        end
    end

    // Terminal marks the TIMEOUT-th enabled cycle, so the owner's registered
    // reaction becomes visible exactly TIMEOUT cycles after counting began
    assign term = (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/adder_host_sequencer.sv
// ============================================================================
// adder_host_sequencer
// Accepts operand sets, drives the adder datapath, issues GO, waits for ENO,
// captures the sum and presents it downstream on a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_host_sequencer
    import adder_host_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SUM_W   = WIDTH + 2,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic             GO,
    input  logic             ENO,
    input  logic [SUM_W-1:0] sum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt
);

    hostst_t state;
    logic    tmr_clear;
    logic    tmr_en;
    logic    tmr_term;

    // Timer restarts while GO is out and runs only while awaiting ENO
    assign tmr_clear = (state == ISSUE);
    assign tmr_en    = (state == WAIT);

    host_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .en    (tmr_en),
        .term  (tmr_term)
    );

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_d      <= '0;
            out_sum   <= '0;
            done_cnt  <= '0;
            GO        <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            GO <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        op_c     <= in_c;
                        op_d     <= in_d;
                        GO       <= 1'b1;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // ENO wins over a simultaneous timeout
                    if (ENO) begin
                        out_sum   <= sum_in;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (tmr_term) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        done_cnt  <= done_cnt + CNT_W'(1);
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    // Terminal until reset
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_host_sequencer.sv
// ============================================================================
// tb_adder_host_sequencer
// Scoreboard testbench for adder_host_sequencer with a controller model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_host_sequencer;

    localparam int WIDTH   = 8;
    localparam int SUM_W   = WIDTH + 2;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b, in_c, in_d;
    logic [WIDTH-1:0] op_a, op_b, op_c, op_d;
    logic             GO;
    logic             ENO;
    logic [SUM_W-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] done_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Controller model controls
    logic             eno_model = 1'b0;
    logic             eno_force = 1'b0;
    logic [SUM_W-1:0] model_sum = '0;
    bit               eno_enable = 1'b1;
    int               cur_delay  = 4;
    int               eno_at     = -1;
    bit               rand_ready = 1'b0;

    // Scoreboard
    int               exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;

    assign ENO    = eno_model | eno_force;
    assign sum_in = model_sum;

    adder_host_sequencer #(
        .WIDTH   (WIDTH),
        .SUM_W   (SUM_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_d      (op_d),
        .GO        (GO),
        .ENO       (ENO),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .err       (err),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller model: answers GO with ENO cur_delay cycles later, summing the
    // operands the host presents to the datapath
    initial begin
        forever begin
            @(negedge clk);
            if (GO && eno_enable) eno_at = cyc + cur_delay;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            eno_model = (cyc == eno_at);
            model_sum = SUM_W'(int'(op_a) + int'(op_b) + int'(op_c) + int'(op_d));
        end
    end

    // Random downstream back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected results and checks handshake behaviour
    initial begin
        bit               prev_valid = 0;
        bit               prev_go    = 0;
        bit               acc_prev   = 0;
        int               exp_rise   = -1;
        logic [SUM_W-1:0] held       = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                model_cnt  = '0;
                prev_valid = 0;
                prev_go    = 0;
                acc_prev   = 0;
                exp_rise   = -1;
            end else begin
                chk("done_cnt", done_cnt, model_cnt);
                if (GO) begin
                    chk("go_pulse_len", prev_go, 0);
                    if (!prev_go) exp_rise = cyc + cur_delay + 1;
                end
                if (acc_prev) chk("valid_drop", out_valid, 0);
                if (out_valid && !prev_valid) begin
                    chk("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("out_sum", out_sum, exp_q.pop_front());
                    chk("valid_latency", cyc, exp_rise);
                    held = out_sum;
                end else if (out_valid) begin
                    chk("sum_stable", out_sum, held);
                    chk("in_ready_hold", in_ready, 0);
                end
                acc_prev = out_valid && out_ready;
                if (acc_prev) model_cnt = model_cnt + 1'b1;
                prev_valid = out_valid;
                prev_go    = GO;
            end
        end
    end

    // Offer one operand set and wait for it to be accepted
    task automatic send_op(input int a, input int b, input int c, input int d);
        bit ok = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = WIDTH'(a); in_b = WIDTH'(b); in_c = WIDTH'(c); in_d = WIDTH'(d);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(a + b + c + d);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_accept: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_idle: in_ready=%0d out_valid=%0d expected idle", in_ready, out_valid);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_go"}, GO, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_d"}, op_d, 0);
    endtask

    initial begin
        int g;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // Spurious ENO in the first cycle after reset release
        reset = 1'b1;
        eno_force = 1'b1;
        @(posedge clk); #1;
        eno_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_out_valid", out_valid, 0);
        chk("post_reset_err", err, 0);
        chk("post_reset_in_ready", in_ready, 1);

        // Single nominal operation
        cur_delay = 4;
        send_op(10, 20, 30, 40);
        wait_idle();
        chk("single_done_cnt", done_cnt, 1);

        // Back-pressure for 5 cycles
        out_ready = 1'b0;
        send_op(10, 20, 30, 40);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_sum", out_sum, 100);
        out_ready = 1'b1;
        wait_idle();
        chk("bp_done_cnt", done_cnt, 2);

        // ENO on the last permissible WAIT cycle wins over timeout
        cur_delay = TIMEOUT;
        send_op(1, 2, 3, 4);
        wait_idle();
        chk("eno_at_limit_err", err, 0);

        // Randomized traffic with random latency and back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cur_delay = $urandom_range(1, TIMEOUT);
            send_op($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            wait_idle();
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();

        // Timeout: controller never answers
        eno_enable = 1'b0;
        send_op(5, 6, 7, 8);
        g = cyc;
        chk("to_go_seen", GO, 1);
        for (int i = 0; i < 40 && !err; i++) @(negedge clk);
        chk("to_err_latency", cyc - g, TIMEOUT + 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("to_err_sticky", err, 1);
            chk("to_in_ready", in_ready, 0);
            chk("to_busy", busy, 1);
        end
        @(posedge clk); #1;
        eno_force = 1'b1;
        @(posedge clk); #1;
        eno_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_eno_ignored", out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_reset_vals("to_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        eno_enable = 1'b1;

        // Reset asserted in WAIT two cycles after GO; the later ENO is ignored
        cur_delay = 4;
        send_op(1, 2, 3, 4);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_late_eno_valid", out_valid, 0);
        chk("mid_late_in_ready", in_ready, 1);
        chk("mid_late_done_cnt", done_cnt, 0);

        // Max operands and counter wrap over 256 operations
        for (int n = 0; n < 256; n++) begin
            if (n % 16 == 0)
                send_op(255, 255, 255, 255);
            else
                send_op($urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255));
            wait_idle();
        end
        chk("wrap_done_cnt", done_cnt, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
